// File: rtl/serial_extreme_finder_if.sv
// Handshake bundle for the bit-serial max/min finder.
// master: frame source (start/mode/bit_in/bit_valid); slave: finder (status/result).
interface serial_extreme_finder_if #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 2
);
   logic             start;
   logic             mode;
   logic             bit_in;
   logic             bit_valid;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [IDX_W-1:0] result_idx;
   logic [1:0]       cmp_state;

   modport master (
      output start, mode, bit_in, bit_valid,
      input  busy, done, result, result_idx, cmp_state
   );

   modport slave (
      input  start, mode, bit_in, bit_valid,
      output busy, done, result, result_idx, cmp_state
   );
endinterface

// File: rtl/serial_extreme_finder.sv
// Bit-serial max/min finder over a frame of COUNT unsigned WIDTH-bit numbers, MSB first.
// Ports: clk, rst_n (sync, active-low), bus (slave: start/mode/bit_in/bit_valid in,
// busy/done/result/result_idx/cmp_state out).
module serial_extreme_finder #(
   parameter int WIDTH = 8,
   parameter int COUNT = 4,
   parameter int IDX_W = 2
) (
   input logic                clk,
   input logic                rst_n,
   serial_extreme_finder_if.slave bus
);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CMAX = CW'(COUNT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [BW-1:0]    r_bit_cnt;
   logic [CW-1:0]    r_num_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_best;
   logic [IDX_W-1:0] r_best_idx;
   logic [WIDTH-1:0] r_result;
   logic [IDX_W-1:0] r_result_idx;
   logic [1:0]       r_cmp;
   logic             r_mode;

   logic             w_b;
   logic [1:0]       w_next;
   logic             w_take;
   logic             w_accept;
   logic             w_last_bit;
   logic             w_last_num;
   logic             w_start_ok;
   logic [WIDTH-1:0] w_incoming;
   logic             w_busy;
   logic             w_done;

   assign w_b        = r_best[BMAX - r_bit_cnt];
   assign w_incoming = {r_shift[WIDTH-2:0], bus.bit_in};
   assign w_accept   = (r_state == RUN) && bus.bit_valid;
   assign w_last_bit = (r_bit_cnt == BMAX);
   assign w_last_num = (r_num_cnt == CMAX);
   assign w_start_ok = (r_state != RUN) && bus.start;

   // Compare code goes sticky at the first differing bit.
   always_comb begin
      w_next = r_cmp;
      if (r_cmp == 2'd2) begin
         if (bus.bit_in == w_b) w_next = 2'd2;
         else                   w_next = bus.bit_in ? 2'd1 : 2'd0;
      end
   end

   // Ties keep the stored best, so the earliest index wins.
   assign w_take = (r_num_cnt == '0)
                || (!r_mode && (w_next == 2'd1))
                || ( r_mode && (w_next == 2'd0));

   always_comb begin
      w_state_nx = r_state;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) w_state_nx = RUN;
         end
         RUN: begin
            w_busy = 1'b1;
            if (bus.bit_valid && w_last_bit && w_last_num)
               w_state_nx = DONE;
         end
         DONE: begin
            w_done     = 1'b1;
            w_state_nx = bus.start ? RUN : IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_num_cnt    <= '0;
         r_shift      <= '0;
         r_best       <= '0;
         r_best_idx   <= '0;
         r_result     <= '0;
         r_result_idx <= '0;
         r_cmp        <= 2'd2;
         r_mode       <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         if (w_start_ok) begin
            r_bit_cnt <= '0;
            r_num_cnt <= '0;
            r_cmp     <= 2'd2;
            r_mode    <= bus.mode;
         end else if (w_accept) begin
            r_shift <= w_incoming;
            if (w_last_bit) begin
               r_bit_cnt <= '0;
               r_cmp     <= 2'd2;
               if (w_take) begin
                  r_best     <= w_incoming;
                  r_best_idx <= IDX_W'(r_num_cnt);
               end
               if (w_last_num) begin
                  r_num_cnt    <= '0;
                  r_result     <= w_take ? w_incoming : r_best;
                  r_result_idx <= w_take ? IDX_W'(r_num_cnt) : r_best_idx;
               end else begin
                  r_num_cnt <= r_num_cnt + 1'b1;
               end
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
               r_cmp     <= w_next;
            end
         end
      end
   end

   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.result     = r_result;
   assign bus.result_idx = r_result_idx;
   assign bus.cmp_state  = r_cmp;
endmodule

// File: tb/tb_serial_extreme_finder.sv
// Directed bench for serial_extreme_finder (WIDTH=8, COUNT=4).
// Drives frames bit by bit and checks status, compare code and results.
module tb_serial_extreme_finder;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;

   serial_extreme_finder_if #(.WIDTH(8), .IDX_W(2)) bus ();

   serial_extreme_finder #(.WIDTH(8), .COUNT(4), .IDX_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_frame(input logic m);
      bus.start = 1'b1;
      bus.mode  = m;
      step();
      bus.start = 1'b0;
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic send_bit(input logic b, input int maxgap);
      if (maxgap > 0) begin
         repeat ($urandom_range(maxgap, 1)) begin
            bus.bit_valid = 1'b0;
            step();
         end
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      step();
      bus.bit_valid = 1'b0;
   endtask

   task automatic send_num(input logic [7:0] v, input int maxgap,
                           input bit trace);
      for (int i = 7; i >= 0; i--) begin
         if (trace)
            check("cmp_trace", {30'd0, bus.cmp_state},
                  (i == 7) ? 32'd2 : 32'd1);
         send_bit(v[i], maxgap);
      end
   endtask

   task automatic frame(input string tag, input logic m,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input int maxgap, input bit trace_b,
                        input logic [7:0] exp_r, input logic [1:0] exp_i);
      start_frame(m);
      send_num(a, maxgap, 1'b0);
      send_num(b, maxgap, trace_b);
      send_num(c, maxgap, 1'b0);
      check({tag, "_no_early_done"}, {31'd0, bus.done}, 32'd0);
      send_num(d, maxgap, 1'b0);
      check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_result"}, {24'd0, bus.result}, {24'd0, exp_r});
      check({tag, "_idx"}, {30'd0, bus.result_idx}, {30'd0, exp_i});
      check({tag, "_cmp_idle"}, {30'd0, bus.cmp_state}, 32'd2);
   endtask

   task automatic post_done(input string tag, input logic [7:0] exp_r);
      step();
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_hold"}, {24'd0, bus.result}, {24'd0, exp_r});
   endtask

   initial begin
      n_checks      = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.mode      = 1'b0;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      step();
      step();
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_result", {24'd0, bus.result}, 32'd0);
      check("rst_idx", {30'd0, bus.result_idx}, 32'd0);
      check("rst_cmp", {30'd0, bus.cmp_state}, 32'd2);
      rst_n = 1'b1;
      step();

      frame("t1", 1'b0, 8'h12, 8'hA5, 8'h3C, 8'hA5, 0, 1'b0, 8'hA5, 2'd1);
      post_done("t1", 8'hA5);

      frame("t2", 1'b1, 8'h80, 8'h7F, 8'h01, 8'hFF, 0, 1'b0, 8'h01, 2'd2);
      post_done("t2", 8'h01);

      frame("t3", 1'b0, 8'h40, 8'h41, 8'h00, 8'h00, 0, 1'b0, 8'h41, 2'd1);
      post_done("t3", 8'h41);

      frame("t4", 1'b0, 8'h12, 8'hA5, 8'h3C, 8'hA5, 5, 1'b1, 8'hA5, 2'd1);
      post_done("t4", 8'hA5);

      start_frame(1'b0);
      send_num(8'hFF, 0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_rst_done", {31'd0, bus.done}, 32'd0);
      check("t5_rst_result", {24'd0, bus.result}, 32'd0);
      check("t5_rst_idx", {30'd0, bus.result_idx}, 32'd0);
      check("t5_rst_cmp", {30'd0, bus.cmp_state}, 32'd2);
      step();
      check("t5_no_done", {31'd0, bus.done}, 32'd0);

      start_frame(1'b0);
      send_num(8'h05, 0, 1'b0);
      send_num(8'h09, 0, 1'b0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("t5_start_ignored", {31'd0, bus.busy}, 32'd1);
      send_num(8'h03, 0, 1'b0);
      send_num(8'h09, 0, 1'b0);
      check("t5_done", {31'd0, bus.done}, 32'd1);
      check("t5_result", {24'd0, bus.result}, 32'h09);
      check("t5_idx", {30'd0, bus.result_idx}, 32'd1);
      post_done("t5", 8'h09);

      frame("t6", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 8'h00, 2'd0);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      check("t6_restart_busy", {31'd0, bus.busy}, 32'd1);
      check("t6_restart_done", {31'd0, bus.done}, 32'd0);
      send_num(8'h33, 0, 1'b0);
      send_num(8'h44, 0, 1'b0);
      send_num(8'h22, 0, 1'b0);
      send_num(8'h11, 0, 1'b0);
      check("t6b_done", {31'd0, bus.done}, 32'd1);
      check("t6b_result", {24'd0, bus.result}, 32'h11);
      check("t6b_idx", {30'd0, bus.result_idx}, 32'd3);
      post_done("t6b", 8'h11);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
